display_sequencer: RTL

Controller that shares the six seven-segment displays between up to four 24-bit BCD sources, such as the two stored birthdays and a switch-derived value. It selects one source at a time and advances either automatically after a dwell period or on a debounced button press. Between sources it blanks the displays. It sits between the constant/switch sources and the seven-segment decoder stage in the board top level.

---
 rtl/display_sequencer_pkg.sv | 24 ++
 rtl/display_sequencer_button_debounce.sv | 43 ++++
 rtl/display_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/display_sequencer_pkg.sv
// Shared definitions for the display sequencer: source count, BCD width,
// sequencer state encoding and the round-robin source search.
package display_sequencer_pkg;

   localparam int NSRC  = 4;
   localparam int BCD_W = 24;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2
   } state_t;

   // First enabled index after cur (cur+1, cur+2, ... with wrap); falls back to cur.
   function automatic logic [1:0] next_index(input logic [1:0] cur, input logic [NSRC-1:0] en);
      logic [1:0] idx;
      next_index = cur;
      for (int k = NSRC - 1; k >= 1; k--) begin
         idx = cur + 2'(k);
         if (en[idx]) next_index = idx;
      end
   endfunction

endpackage

// File: rtl/display_sequencer_button_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted press (debounced 1->0 edge) of an active-low button.
module button_debounce #(
   parameter int DEB = 500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic bn,
   output logic press
);

   localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;

   logic          s1;
   logic          s2;
   logic          level;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         s1    <= bn;
         s2    <= s1;
         press <= 1'b0;
         // Any sample agreeing with the accepted level restarts the stability window.
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB - 1)) begin
            level <= s2;
            cnt   <= '0;
            press <= ~s2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/display_sequencer.sv
// Shares the six seven-segment digits between four BCD sources, rotating on a
// dwell timer and/or a debounced button, with a blanking gap between sources.
module display_sequencer
   import display_sequencer_pkg::*;
#(
   parameter int DWELL = 50_000_000,
   parameter int DEB   = 500_000,
   parameter int BLANK = 5_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BCD_W-1:0] a0,
   input  logic [BCD_W-1:0] a1,
   input  logic [BCD_W-1:0] a2,
   input  logic [BCD_W-1:0] a3,
   input  logic [NSRC-1:0]  en,
   input  logic             bn,
   input  logic             mode,
   output logic [BCD_W-1:0] x,
   output logic [1:0]       sel,
   output logic             blank
);

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int GW = (BLANK > 1) ? $clog2(BLANK) : 1;

   state_t           state;
   logic [DW-1:0]    dwell;
   logic [GW-1:0]    gap;
   logic             press;
   logic [BCD_W-1:0] src [NSRC];
   logic [1:0]       nxt;
   logic [1:0]       first;
   logic             expire;
   logic             advance;

   button_debounce #(.DEB(DEB)) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .bn    (bn),
      .press (press)
   );

   assign src[0] = a0;
   assign src[1] = a1;
   assign src[2] = a2;
   assign src[3] = a3;

   // Searching from index 3 yields the lowest enabled index.
   assign first   = next_index(2'd3, en);
   assign nxt     = next_index(sel, en);
   assign expire  = mode && (dwell == DW'(DWELL - 1));
   assign advance = expire || press || !en[sel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sel   <= 2'd0;
         x     <= '0;
         blank <= 1'b1;
         dwell <= '0;
         gap   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en != '0) begin
                  state <= SHOW;
                  sel   <= first;
                  x     <= src[first];
                  blank <= 1'b0;
                  dwell <= '0;
               end
            end
            SHOW: begin
               x <= src[sel];
               if (advance) begin
                  dwell <= '0;
                  if (en == '0) begin
                     state <= IDLE;
                     blank <= 1'b1;
                  end else if (nxt != sel) begin
                     state <= GAP;
                     sel   <= nxt;
                     blank <= 1'b1;
                     gap   <= GW'(BLANK - 1);
                  end
               end else if (mode) begin
                  dwell <= dwell + 1'b1;
               end
            end
            GAP: begin
               // Presses are dropped here; a source disabled meanwhile is caught in SHOW.
               if (gap == '0) begin
                  state <= SHOW;
                  blank <= 1'b0;
                  x     <= src[sel];
               end else begin
                  gap <= gap - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               blank <= 1'b1;
            end
         endcase
      end
   end

endmodule
